// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-write bundle for the round-robin FIFO write arbiter.
// The slave modport is the arbiter's side. The master modport is the producer/FIFO side.
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_write;
   logic [DATA_WIDTH-1:0]         fifo_wdata;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;

   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_write, fifo_wdata, grant, busy
   );

   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_write, fifo_wdata, grant, busy
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// Each grant allows a burst of up to MAX_BURST words, and fifo_full throttles the burst.
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_write_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state;
   logic [NUM_REQ-1:0] grant_q;
   logic               busy_q;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   owner_idx;
   logic [CNT_W-1:0]   burst_cnt;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_hit;
   logic               in_burst;
   logic               owner_valid;
   logic               owner_last;
   logic               xfer;
   logic               burst_end;
   logic [IDX_W-1:0]   next_ptr;

   // The search runs from the farthest offset down to offset 0.
   // The last hit therefore wins, which gives the first valid index at or after rr_ptr.
   always_comb begin
      pick_idx = '0;
      pick_hit = 1'b0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         int c;
         c = int'(rr_ptr) + off;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (bus.req_valid[c]) begin
            pick_idx = IDX_W'(c);
            pick_hit = 1'b1;
         end
      end
   end

   // NOTE: the strobe and the ready bits are gated with rst combinationally.
   // As a result, no write escapes in the reset cycle, even though the state registers clear only at the next edge.
   assign in_burst    = (state == BURST) && !rst;
   assign owner_valid = bus.req_valid[owner_idx];
   assign owner_last  = bus.req_last[owner_idx];
   assign xfer        = in_burst && !bus.fifo_full && owner_valid;
   assign burst_end   = !owner_valid ||
                        (xfer && (owner_last || burst_cnt == CNT_W'(MAX_BURST - 1)));
   assign next_ptr    = (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;

   assign bus.req_ready  = (in_burst && !bus.fifo_full) ? grant_q : '0;
   assign bus.fifo_write = xfer;
   assign bus.fifo_wdata = bus.req_data[owner_idx*DATA_WIDTH +: DATA_WIDTH];
   assign bus.grant      = grant_q;
   assign bus.busy       = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         rr_ptr    <= '0;
         owner_idx <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_hit) begin
                  state     <= BURST;
                  grant_q   <= NUM_REQ'(1) << pick_idx;
                  busy_q    <= 1'b1;
                  owner_idx <= pick_idx;
                  burst_cnt <= '0;
               end
            end
            BURST: begin
               if (xfer) burst_cnt <= burst_cnt + 1'b1;
               // A stalled owner keeps valid high, so a stall never reaches burst_end.
               if (burst_end) begin
                  state   <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  rr_ptr  <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter.
// A transaction-level model predicts each cycle's outputs, and a negedge monitor compares them with the DUT.
module tb_fifo_write_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int MAX_BURST  = 4;

   typedef struct {
      logic [NUM_REQ-1:0]    grant;
      logic                  busy;
      logic [NUM_REQ-1:0]    ready;
      logic                  wr;
      logic [DATA_WIDTH-1:0] wdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

   fifo_write_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   exp_t exp_q[$];
   logic [DATA_WIDTH-1:0] wr_log[$];

   // The model tracks which producer owns the port (-1 = nobody).
   // It also tracks how many words this grant has moved and where the round-robin search starts next.
   int m_owner = -1;
   int m_words = 0;
   int m_ptr   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input bit r, input logic [NUM_REQ-1:0] v,
                        input logic [NUM_REQ*DATA_WIDTH-1:0] d,
                        input logic [NUM_REQ-1:0] l, input bit f);
      exp_t e;
      rst = r;
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
      bus.fifo_full = f;
      e.grant = (m_owner < 0) ? '0 : NUM_REQ'(1) << m_owner;
      e.busy  = (m_owner >= 0);
      e.ready = '0;
      e.wr    = 1'b0;
      e.wdata = '0;
      if (!r && m_owner >= 0) begin
         e.ready = f ? '0 : NUM_REQ'(1) << m_owner;
         e.wr    = v[m_owner] && !f;
         e.wdata = d[m_owner*DATA_WIDTH +: DATA_WIDTH];
      end
      exp_q.push_back(e);
      if (r) begin
         m_owner = -1; m_words = 0; m_ptr = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (m_owner < 0 && v[(m_ptr + k) % NUM_REQ]) m_owner = (m_ptr + k) % NUM_REQ;
         end
         m_words = 0;
      end else begin
         bit done;
         done = !v[m_owner];
         if (e.wr) begin
            m_words++;
            if (l[m_owner] || m_words == MAX_BURST) done = 1'b1;
         end
         if (done) begin
            m_ptr   = (m_owner + 1) % NUM_REQ;
            m_owner = -1;
         end
      end
   endtask

   task automatic drive(input bit r, input logic [NUM_REQ-1:0] v,
                        input logic [NUM_REQ*DATA_WIDTH-1:0] d,
                        input logic [NUM_REQ-1:0] l, input bit f);
      tick();
      apply(r, v, d, l, f);
   endtask

   // Monitor: compares each cycle's outputs mid-cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant", 64'(bus.grant), 64'(e.grant));
            check("busy", 64'(bus.busy), 64'(e.busy));
            check("req_ready", 64'(bus.req_ready), 64'(e.ready));
            check("fifo_write", 64'(bus.fifo_write), 64'(e.wr));
            if (e.wr) check("fifo_wdata", 64'(bus.fifo_wdata), 64'(e.wdata));
            if (bus.fifo_write) wr_log.push_back(bus.fifo_wdata);
         end
      end
   end

   initial begin
      logic [31:0] d;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.fifo_full = 1'b0;

      // Test 1: reset held with every requester valid, then release.
      drive(1, 4'b1111, 32'h0, 4'b0, 0);
      drive(1, 4'b1111, 32'h0, 4'b0, 0);
      check("t1_rst_grant", 64'(bus.grant), 64'h0);
      check("t1_rst_ready", 64'(bus.req_ready), 64'h0);
      drive(0, 4'b1111, 32'h0, 4'b0, 0);
      tick();
      check("t1_first_grant", 64'(bus.grant), 64'h1);
      apply(0, 4'b0000, 32'h0, 4'b0, 0);
      drive(0, 4'b0000, 32'h0, 4'b0, 0);

      // Test 2: req1 sends 0x11, 0x22, 0x33 with last on 0x33.
      tick(); wr_log.delete(); apply(0, 4'b0010, 32'h0000_1100, 4'b0000, 0);
      tick();
      check("t2_grant", 64'(bus.grant), 64'h2);
      apply(0, 4'b0010, 32'h0000_1100, 4'b0000, 0);
      drive(0, 4'b0010, 32'h0000_2200, 4'b0000, 0);
      drive(0, 4'b0010, 32'h0000_3300, 4'b0010, 0);
      drive(0, 4'b0000, 32'h0, 4'b0, 0);
      tick();
      check("t2_nwrites", 64'(wr_log.size()), 64'd3);
      if (wr_log.size() == 3) begin
         check("t2_w0", 64'(wr_log[0]), 64'h11);
         check("t2_w1", 64'(wr_log[1]), 64'h22);
         check("t2_w2", 64'(wr_log[2]), 64'h33);
      end
      check("t2_idle", 64'(bus.busy), 64'h0);

      // Test 3: all requesters valid and never last, so each grant runs exactly MAX_BURST words.
      wr_log.delete();
      apply(0, 4'b1111, $urandom, 4'b0, 0);
      for (int i = 1; i < 20; i++) drive(0, 4'b1111, $urandom, 4'b0, 0);
      tick();
      check("t3_nwrites", 64'(wr_log.size()), 64'd16);
      apply(0, 4'b0000, 32'h0, 4'b0, 0);

      // Test 4: req2 stalls on fifo_full for 5 cycles after its first word.
      drive(0, 4'b0000, 32'h0, 4'b0, 0);
      tick(); wr_log.delete(); apply(0, 4'b0100, 32'h00A1_0000, 4'b0, 0);
      drive(0, 4'b0100, 32'h00A1_0000, 4'b0, 0);
      for (int i = 0; i < 5; i++) drive(0, 4'b0100, 32'h00A2_0000, 4'b0100, 1);
      drive(0, 4'b0100, 32'h00A2_0000, 4'b0, 0);
      drive(0, 4'b0100, 32'h00A3_0000, 4'b0, 0);
      drive(0, 4'b0100, 32'h00A4_0000, 4'b0, 0);
      drive(0, 4'b0000, 32'h0, 4'b0, 0);
      tick();
      check("t4_nwrites", 64'(wr_log.size()), 64'd4);
      if (wr_log.size() == 4) check("t4_last", 64'(wr_log[3]), 64'hA4);
      apply(0, 4'b0000, 32'h0, 4'b0, 0);

      // Test 5: the owner (req3) drops valid after 2 words, and the waiting req0 then gets the port.
      drive(0, 4'b1000, 32'h3100_0000, 4'b0, 0);
      drive(0, 4'b1001, 32'h3100_0000, 4'b0, 0);
      drive(0, 4'b1001, 32'h3200_0000, 4'b0, 0);
      drive(0, 4'b0001, 32'h0000_0005, 4'b0, 0);
      drive(0, 4'b0001, 32'h0000_0005, 4'b0, 0);
      tick();
      check("t5_next_grant", 64'(bus.grant), 64'h1);
      apply(0, 4'b0000, 32'h0, 4'b0, 0);

      // Test 6: reset lands on the cycle of the second word.
      drive(0, 4'b0000, 32'h0, 4'b0, 0);
      drive(0, 4'b0010, 32'h0000_6100, 4'b0, 0);
      drive(0, 4'b0010, 32'h0000_6100, 4'b0, 0);
      drive(1, 4'b0010, 32'h0000_6200, 4'b0, 0);
      tick();
      check("t6_grant_clr", 64'(bus.grant), 64'h0);
      check("t6_busy_clr", 64'(bus.busy), 64'h0);
      apply(0, 4'b0000, 32'h0, 4'b0, 0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [NUM_REQ-1:0] v, l;
         d = $urandom;
         v = NUM_REQ'($urandom) | NUM_REQ'($urandom);
         l = NUM_REQ'($urandom) & NUM_REQ'($urandom) & NUM_REQ'($urandom);
         drive(($urandom_range(0, 99) == 0), v, d, l, ($urandom_range(0, 3) == 0));
      end
      drive(0, 4'b0000, 32'h0, 4'b0, 0);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
